alu_bist_ctrl: RTL
==================

ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL provide parameter ALU_LAT, default 1, meaning clock edges from operands presented on alu_a/alu_b/alu_sel to the matching alu_y; legal range 1..4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
REQ-005 SHALL have ports alu_a, alu_b  output  4 each  signed operands driven to the ALU under test.
REQ-006 SHALL have port alu_sel  output  4  operation select driven to the ALU under test.
REQ-007 SHALL have port alu_y  input  8  signed ALU result.
REQ-008 SHALL have ports busy, done, pass  output  1 each  sweep in progress / sweep finished / finished with zero errors.
REQ-009 SHALL have port err_count  output  13  number of mismatching vectors in the current sweep.
REQ-010 SHALL have ports fail_vec  output  12  {sel,a,b} of first mismatch; fail_y, fail_exp  output  8 each  observed and expected result of first mismatch.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE/DONE + start -> RUN; RUN -> DRAIN after vector index 4095 is issued; DRAIN -> DONE once the last vector is compared.
REQ-012 SHALL, in RUN, issue one vector per cycle from a 12-bit index {sel[3:0],a[3:0],b[3:0]} starting at 0 and incrementing by 1, all 4096 combinations, outputs registered.
REQ-013 SHALL compute expected results on operands sign-extended to 8 bits, 8-bit two's-complement arithmetic: 0000 a+1, 0001 b+1, 0010 a, 0011 b, 0100 a-1, 0101 a*b, 0110 a+b, 0111 a-b.
REQ-014 SHALL compute logical expected results (sel[3]=1) on 4 bits then sign-extend: 1000 ~a, 1001 ~b, 1010 a&b, 1011 a|b, 1100 a^b, 1101 ~(a^b), 1110 ~(a&b), 1111 ~(a|b).
REQ-015 SHALL carry expected value, vector index and a valid tag through an ALU_LAT-deep pipeline and compare alu_y with the tagged expected value exactly ALU_LAT cycles after the vector is presented.
REQ-016 SHALL increment err_count by 1 per mismatch; err_count saturates at 4096 by construction (no wrap).
REQ-017 SHALL capture fail_vec/fail_y/fail_exp on the first mismatch of a sweep only; later mismatches leave them unchanged.
REQ-018 SHALL hold busy=1 in RUN and DRAIN; done=1 and pass=(err_count==0) only in DONE; pass=0 elsewhere.
REQ-019 SHALL ignore start in RUN and DRAIN (no restart, no counter clear).
REQ-020 SHALL, on start in DONE, clear err_count, fail_*, done, pass, index and pipeline tags in the same edge that enters RUN.
REQ-021 SHALL hold alu_a/alu_b/alu_sel at their last issued value during DRAIN and DONE; comparison only on valid tags (no compares in IDLE/DONE).
REQ-022 SHALL reach DONE exactly 4096+ALU_LAT cycles after the edge sampling start.

Reset
REQ-023 SHALL, when rst_n=0, asynchronously force state IDLE and all outputs (alu_a, alu_b, alu_sel, busy, done, pass, err_count, fail_vec, fail_y, fail_exp) and all pipeline tags to 0.
REQ-024 SHALL abandon a sweep on reset mid-RUN/DRAIN with no partial result; a subsequent start begins at index 0.

Verification
REQ-025 Correct registered ALU model, ALU_LAT=1, pulse start -> busy for 4097 cycles, done=1, pass=1, err_count=0.
REQ-026 Model faulted so sel=0111 returns a-b+1 -> err_count=256, fail_vec=12'h700, fail_exp=8'h00, fail_y=8'h01, pass=0.
REQ-027 Spot expected values: a=3,b=-2,sel=0101 -> 8'hFA; a=-8,b=-8,sel=0101 -> 8'h40; a=7,sel=0000 -> 8'h08; a=-8,sel=0100 -> 8'hF7; a=5,b=3,sel=1111 -> 8'hF8.
REQ-028 ALU_LAT=2 with 2-stage model -> pass=1; ALU_LAT=1 against 2-stage model -> pass=0, err_count>0.
REQ-029 rst_n low at index 1000 -> all outputs 0 immediately; start again -> clean sweep, pass=1.
REQ-030 start pulsed during RUN -> ignored, DONE still at cycle 4097; start in DONE -> counters cleared, second sweep identical result.

Source files
------------

// File: rtl/alu_bist_ctrl.sv
// Exhaustive built-in self-test sweep for a 4-bit ALU: issues all 4096 {sel,a,b}
// vectors, compares alu_y against a latency-matched expected value, logs errors.
module alu_bist_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [12:0] err_count,
  output logic [11:0] fail_vec,
  output logic [7:0]  fail_y,
  output logic [7:0]  fail_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] vec_q, vec_d;
  logic        vld_q, vld_d;
  logic [12:0] err_q, err_d;
  logic [11:0] fv_q, fv_d;
  logic [7:0]  fy_q, fy_d, fe_q, fe_d;
  logic        pv_q [ALU_LAT];
  logic        pv_d [ALU_LAT];
  logic [7:0]  pe_q [ALU_LAT];
  logic [7:0]  pe_d [ALU_LAT];
  logic [11:0] pi_q [ALU_LAT];
  logic [11:0] pi_d [ALU_LAT];
  logic [7:0]  exp_now;
  logic        mism;
  logic        last_cmp;

  function automatic logic [7:0] expect_y(input logic [11:0] v);
    logic [7:0] a, b, r;
    logic [3:0] l;
    a = {{4{v[7]}}, v[7:4]};
    b = {{4{v[3]}}, v[3:0]};
    r = '0;
    l = '0;
    if (!v[11]) begin
      case (v[10:8])
        3'd0:    r = a + 8'd1;
        3'd1:    r = b + 8'd1;
        3'd2:    r = a;
        3'd3:    r = b;
        3'd4:    r = a - 8'd1;
        3'd5:    r = a * b;  // low byte of the product is sign-agnostic
        3'd6:    r = a + b;
        default: r = a - b;
      endcase
    end else begin
      case (v[10:8])
        3'd0:    l = ~v[7:4];
        3'd1:    l = ~v[3:0];
        3'd2:    l = v[7:4] & v[3:0];
        3'd3:    l = v[7:4] | v[3:0];
        3'd4:    l = v[7:4] ^ v[3:0];
        3'd5:    l = ~(v[7:4] ^ v[3:0]);
        3'd6:    l = ~(v[7:4] & v[3:0]);
        default: l = ~(v[7:4] | v[3:0]);
      endcase
      r = {{4{l[3]}}, l};
    end
    return r;
  endfunction

  always_comb begin
    exp_now  = expect_y(vec_q);
    mism     = pv_q[ALU_LAT-1] && (alu_y != pe_q[ALU_LAT-1]);
    last_cmp = pv_q[ALU_LAT-1] && (pi_q[ALU_LAT-1] == '1);

    state_d = state_q;
    vec_d   = vec_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    fv_d    = fv_q;
    fy_d    = fy_q;
    fe_d    = fe_q;
    pv_d[0] = vld_q;
    pe_d[0] = exp_now;
    pi_d[0] = vec_q;
    for (int unsigned i = 1; i < ALU_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pi_d[i] = pi_q[i-1];
    end

    if (mism) begin
      err_d = err_q + 13'd1;
      if (err_q == '0) begin
        fv_d = pi_q[ALU_LAT-1];
        fy_d = alu_y;
        fe_d = pe_q[ALU_LAT-1];
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          vld_d   = 1'b1;
          err_d   = '0;
          fv_d    = '0;
          fy_d    = '0;
          fe_d    = '0;
          for (int unsigned i = 0; i < ALU_LAT; i++) begin
            pv_d[i] = 1'b0;
            pe_d[i] = '0;
            pi_d[i] = '0;
          end
        end
      end
      RUN: begin
        // vec_q is the vector currently on the ALU inputs; it holds after 4095
        if (vec_q == '1) begin
          state_d = DRAIN;
        end else begin
          vec_d = vec_q + 12'd1;
          vld_d = 1'b1;
        end
      end
      DRAIN: begin
        if (last_cmp) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
      fy_q    <= '0;
      fe_q    <= '0;
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= '0;
        pi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fy_q    <= fy_d;
      fe_q    <= fe_d;
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pe_q[i] <= pe_d[i];
        pi_q[i] <= pi_d[i];
      end
    end
  end

  assign alu_sel   = vec_q[11:8];
  assign alu_a     = vec_q[7:4];
  assign alu_b     = vec_q[3:0];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fv_q;
  assign fail_y    = fy_q;
  assign fail_exp  = fe_q;

endmodule
